// File: rtl/memory_access.sv
// Memory stage: turns an execute bundle into a single data-memory access with
// byte-lane steering, load extraction and misalignment detection.
module memory_access #(
    parameter int D_WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               valid_e_i,
    input  logic               reg_write_e_i,
    input  logic [1:0]         result_src_e_i,
    input  logic               mem_write_e_i,
    input  logic [2:0]         ins_3_i,
    input  logic [D_WIDTH-1:0] alu_result_e_i,
    input  logic [D_WIDTH-1:0] write_data_e_i,
    input  logic [4:0]         rd_e_i,
    input  logic [D_WIDTH-1:0] pc_plus_4e_i,
    output logic               stall_m_o,
    output logic               mem_req_o,
    output logic               mem_we_o,
    output logic [D_WIDTH-1:0] mem_addr_o,
    output logic [D_WIDTH-1:0] mem_wdata_o,
    output logic [3:0]         mem_be_o,
    input  logic               mem_ack_i,
    input  logic [D_WIDTH-1:0] mem_rdata_i,
    output logic               valid_m_o,
    output logic               reg_write_m_o,
    output logic [1:0]         result_src_m_o,
    output logic [4:0]         rd_m_o,
    output logic [D_WIDTH-1:0] alu_result_m_o,
    output logic [D_WIDTH-1:0] read_data_m_o,
    output logic [D_WIDTH-1:0] pc_plus_4m_o,
    output logic               misaligned_o
);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t state_q, state_d;

    // Bundle captured at the start of a memory access
    logic               l_reg_write_q, l_reg_write_d;
    logic [1:0]         l_result_src_q, l_result_src_d;
    logic [2:0]         l_funct3_q, l_funct3_d;
    logic [D_WIDTH-1:0] l_alu_result_q, l_alu_result_d;
    logic [4:0]         l_rd_q, l_rd_d;
    logic [D_WIDTH-1:0] l_pc_plus_4_q, l_pc_plus_4_d;

    logic               mem_we_q, mem_we_d;
    logic [D_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [D_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]         mem_be_q, mem_be_d;

    logic               valid_m_q, valid_m_d;
    logic               reg_write_m_q, reg_write_m_d;
    logic [1:0]         result_src_m_q, result_src_m_d;
    logic [4:0]         rd_m_q, rd_m_d;
    logic [D_WIDTH-1:0] alu_result_m_q, alu_result_m_d;
    logic [D_WIDTH-1:0] read_data_m_q, read_data_m_d;
    logic [D_WIDTH-1:0] pc_plus_4m_q, pc_plus_4m_d;
    logic               misaligned_q, misaligned_d;

    logic               capture;
    logic               e_mem_op;
    logic               e_misaligned;
    logic [D_WIDTH-1:0] e_wdata;
    logic [3:0]         e_be;
    logic [7:0]         ld_byte;
    logic [15:0]        ld_half;
    logic [D_WIDTH-1:0] ld_data;

    assign capture  = valid_e_i && (state_q == S_IDLE);
    assign e_mem_op = mem_write_e_i || (result_src_e_i == 2'b01);

    always_comb begin
        e_misaligned = 1'b0;
        e_wdata      = write_data_e_i;
        e_be         = 4'b1111;
        case (ins_3_i[1:0])
            2'b00: begin
                e_wdata = {(D_WIDTH/8){write_data_e_i[7:0]}};
                e_be    = 4'b0001 << alu_result_e_i[1:0];
            end
            2'b01: begin
                e_misaligned = alu_result_e_i[0];
                e_wdata      = {(D_WIDTH/16){write_data_e_i[15:0]}};
                e_be         = alu_result_e_i[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                e_misaligned = (alu_result_e_i[1:0] != 2'b00);
            end
        endcase
    end

    // Load extraction uses the address and funct3 captured with the request
    always_comb begin
        ld_byte = mem_rdata_i[{l_alu_result_q[1:0], 3'b000} +: 8];
        ld_half = mem_rdata_i[{l_alu_result_q[1], 4'b0000} +: 16];
        case (l_funct3_q[1:0])
            2'b00: ld_data = l_funct3_q[2] ? {{(D_WIDTH-8){1'b0}}, ld_byte}
                                           : {{(D_WIDTH-8){ld_byte[7]}}, ld_byte};
            2'b01: ld_data = l_funct3_q[2] ? {{(D_WIDTH-16){1'b0}}, ld_half}
                                           : {{(D_WIDTH-16){ld_half[15]}}, ld_half};
            default: ld_data = mem_rdata_i;
        endcase
    end

    always_comb begin
        state_d        = state_q;
        l_reg_write_d  = l_reg_write_q;
        l_result_src_d = l_result_src_q;
        l_funct3_d     = l_funct3_q;
        l_alu_result_d = l_alu_result_q;
        l_rd_d         = l_rd_q;
        l_pc_plus_4_d  = l_pc_plus_4_q;
        mem_we_d       = mem_we_q;
        mem_addr_d     = mem_addr_q;
        mem_wdata_d    = mem_wdata_q;
        mem_be_d       = mem_be_q;
        valid_m_d      = 1'b0;
        misaligned_d   = 1'b0;
        reg_write_m_d  = reg_write_m_q;
        result_src_m_d = result_src_m_q;
        rd_m_d         = rd_m_q;
        alu_result_m_d = alu_result_m_q;
        read_data_m_d  = read_data_m_q;
        pc_plus_4m_d   = pc_plus_4m_q;

        case (state_q)
            S_IDLE: begin
                if (capture) begin
                    if (!e_mem_op || e_misaligned) begin
                        // Completes in place; a misaligned access retires with no writeback
                        valid_m_d      = 1'b1;
                        misaligned_d   = e_mem_op;
                        reg_write_m_d  = reg_write_e_i && !e_mem_op;
                        result_src_m_d = result_src_e_i;
                        rd_m_d         = rd_e_i;
                        alu_result_m_d = alu_result_e_i;
                        pc_plus_4m_d   = pc_plus_4e_i;
                    end else begin
                        state_d        = S_WAIT;
                        l_reg_write_d  = reg_write_e_i;
                        l_result_src_d = result_src_e_i;
                        l_funct3_d     = ins_3_i;
                        l_alu_result_d = alu_result_e_i;
                        l_rd_d         = rd_e_i;
                        l_pc_plus_4_d  = pc_plus_4e_i;
                        mem_we_d       = mem_write_e_i;
                        mem_addr_d     = {alu_result_e_i[D_WIDTH-1:2], 2'b00};
                        mem_wdata_d    = e_wdata;
                        mem_be_d       = mem_write_e_i ? e_be : 4'b0000;
                    end
                end
            end
            S_WAIT: begin
                if (mem_ack_i) begin
                    state_d        = S_IDLE;
                    valid_m_d      = 1'b1;
                    reg_write_m_d  = l_reg_write_q;
                    result_src_m_d = l_result_src_q;
                    rd_m_d         = l_rd_q;
                    alu_result_m_d = l_alu_result_q;
                    pc_plus_4m_d   = l_pc_plus_4_q;
                    if (!mem_we_q) begin
                        read_data_m_d = ld_data;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            l_reg_write_q  <= 1'b0;
            l_result_src_q <= '0;
            l_funct3_q     <= '0;
            l_alu_result_q <= '0;
            l_rd_q         <= '0;
            l_pc_plus_4_q  <= '0;
            mem_we_q       <= 1'b0;
            mem_addr_q     <= '0;
            mem_wdata_q    <= '0;
            mem_be_q       <= '0;
            valid_m_q      <= 1'b0;
            reg_write_m_q  <= 1'b0;
            result_src_m_q <= '0;
            rd_m_q         <= '0;
            alu_result_m_q <= '0;
            read_data_m_q  <= '0;
            pc_plus_4m_q   <= '0;
            misaligned_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            l_reg_write_q  <= l_reg_write_d;
            l_result_src_q <= l_result_src_d;
            l_funct3_q     <= l_funct3_d;
            l_alu_result_q <= l_alu_result_d;
            l_rd_q         <= l_rd_d;
            l_pc_plus_4_q  <= l_pc_plus_4_d;
            mem_we_q       <= mem_we_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
            mem_be_q       <= mem_be_d;
            valid_m_q      <= valid_m_d;
            reg_write_m_q  <= reg_write_m_d;
            result_src_m_q <= result_src_m_d;
            rd_m_q         <= rd_m_d;
            alu_result_m_q <= alu_result_m_d;
            read_data_m_q  <= read_data_m_d;
            pc_plus_4m_q   <= pc_plus_4m_d;
            misaligned_q   <= misaligned_d;
        end
    end

    assign stall_m_o      = (state_q == S_WAIT);
    assign mem_req_o      = (state_q == S_WAIT);
    assign mem_we_o       = mem_we_q && (state_q == S_WAIT);
    assign mem_addr_o     = mem_addr_q;
    assign mem_wdata_o    = mem_wdata_q;
    assign mem_be_o       = (state_q == S_WAIT) ? mem_be_q : 4'b0000;
    assign valid_m_o      = valid_m_q;
    assign reg_write_m_o  = reg_write_m_q;
    assign result_src_m_o = result_src_m_q;
    assign rd_m_o         = rd_m_q;
    assign alu_result_m_o = alu_result_m_q;
    assign read_data_m_o  = read_data_m_q;
    assign pc_plus_4m_o   = pc_plus_4m_q;
    assign misaligned_o   = misaligned_q;

endmodule
